// File: rtl/rr_quantum_scheduler.sv
// Round-robin preemption timer: runs programmable time slices for NPROC process slots
// and raises a level interrupt on expiry until the kernel acknowledges it.
module rr_quantum_scheduler #(
   parameter int CNT_W           = 16,
   parameter int NPROC           = 8,
   parameter int PID_W           = 3,
   parameter int DEFAULT_QUANTUM = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             quantum_we,
   input  logic [CNT_W-1:0] quantum_in,
   input  logic [NPROC-1:0] proc_en,
   input  logic             irq_ack,
   output logic             running,
   output logic             irq,
   output logic [PID_W-1:0] cur_pid,
   output logic [PID_W-1:0] next_pid,
   output logic             next_valid,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] RESET_Q =
      (DEFAULT_QUANTUM == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_QUANTUM);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_quantum;
   logic [CNT_W-1:0] r_activeQ;
   logic [PID_W-1:0] r_curPid;
   logic [PID_W-1:0] w_nextPid;
   logic [PID_W-1:0] w_startPid;
   logic [PID_W-1:0] w_abovePid;
   logic [PID_W-1:0] w_belowPid;
   logic [PID_W-1:0] w_atOrAbovePid;
   logic             w_aboveFound;
   logic             w_belowFound;
   logic             w_atOrAboveFound;
   logic             w_nextValid;
   logic             w_lastTick;

   assign w_nextValid = |proc_en;
   assign w_lastTick  = (r_count == (r_activeQ - CNT_W'(1)));

   // Cyclic search split into "slots above the current one" and "the rest"; scanning
   // downwards leaves the lowest matching slot in each group.
   always_comb begin
      w_abovePid       = '0;
      w_belowPid       = '0;
      w_atOrAbovePid   = '0;
      w_aboveFound     = 1'b0;
      w_belowFound     = 1'b0;
      w_atOrAboveFound = 1'b0;
      for (int i = NPROC - 1; i >= 0; i--) begin
         if (proc_en[i]) begin
            if (i > int'(r_curPid)) begin
               w_abovePid   = PID_W'(i);
               w_aboveFound = 1'b1;
            end else begin
               w_belowPid   = PID_W'(i);
               w_belowFound = 1'b1;
            end
            if (i >= int'(r_curPid)) begin
               w_atOrAbovePid   = PID_W'(i);
               w_atOrAboveFound = 1'b1;
            end
         end
      end
      w_nextPid  = r_curPid;
      w_startPid = r_curPid;
      if (w_aboveFound) begin
         w_nextPid = w_abovePid;
      end else if (w_belowFound) begin
         w_nextPid = w_belowPid;
      end
      if (w_atOrAboveFound) begin
         w_startPid = w_atOrAbovePid;
      end else if (w_belowFound) begin
         w_startPid = w_belowPid;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Stop always wins over expiry and acknowledge.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start && w_nextValid) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               w_nextState = IDLE;
            end else if (w_lastTick) begin
               w_nextState = EXPIRED;
            end
         end
         EXPIRED: begin
            if (stop) begin
               w_nextState = IDLE;
            end else if (irq_ack) begin
               w_nextState = w_nextValid ? RUN : IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The slice length is frozen into r_activeQ at slice start, so quantum writes only
   // affect later slices.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count   <= '0;
         r_curPid  <= '0;
         r_quantum <= RESET_Q;
         r_activeQ <= RESET_Q;
      end else begin
         if (quantum_we) begin
            r_quantum <= (quantum_in == '0) ? CNT_W'(1) : quantum_in;
         end
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (start && w_nextValid) begin
                  r_activeQ <= r_quantum;
                  r_curPid  <= w_startPid;
               end
            end
            RUN: begin
               if (stop) begin
                  r_count <= '0;
               end else if (!w_lastTick) begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            EXPIRED: begin
               if (stop) begin
                  r_count <= '0;
               end else if (irq_ack) begin
                  r_count <= '0;
                  if (w_nextValid) begin
                     r_curPid  <= w_nextPid;
                     r_activeQ <= r_quantum;
                  end
               end
            end
            default: r_count <= '0;
         endcase
      end
   end

   assign running    = (r_state == RUN);
   assign irq        = (r_state == EXPIRED);
   assign cur_pid    = r_curPid;
   assign next_pid   = w_nextPid;
   assign next_valid = w_nextValid;
   assign count      = r_count;

endmodule

// File: tb/tb_rr_quantum_scheduler.sv
// Directed testbench for rr_quantum_scheduler: slice length, round-robin order,
// quantum programming, stop priority, empty ready mask and asynchronous reset.
module tb_rr_quantum_scheduler;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic        quantum_we;
   logic [15:0] quantum_in;
   logic [7:0]  proc_en;
   logic        irq_ack;
   logic        running;
   logic        irq;
   logic [2:0]  cur_pid;
   logic [2:0]  next_pid;
   logic        next_valid;
   logic [15:0] count;

   int total = 0;
   int bad   = 0;

   rr_quantum_scheduler #(
      .CNT_W(16),
      .NPROC(8),
      .PID_W(3),
      .DEFAULT_QUANTUM(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .stop(stop),
      .quantum_we(quantum_we),
      .quantum_in(quantum_in),
      .proc_en(proc_en),
      .irq_ack(irq_ack),
      .running(running),
      .irq(irq),
      .cur_pid(cur_pid),
      .next_pid(next_pid),
      .next_valid(next_valid),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advances n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      quantum_we = 1'b0;
      quantum_in = '0;
      proc_en    = '0;
      irq_ack    = 1'b0;
      #12;
      checkOutput("rst_running", running, 0);
      checkOutput("rst_irq", irq, 0);
      checkOutput("rst_cur_pid", cur_pid, 0);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_next_valid", next_valid, 0);
      reset   = 1'b0;
      proc_en = 8'b0000_0101;
      #1;
      checkOutput("init_next_pid", next_pid, 2);
      checkOutput("init_next_valid", next_valid, 1);

      // Default 20-cycle slice for slot 0
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("s1_running", running, 1);
      checkOutput("s1_cur_pid", cur_pid, 0);
      checkOutput("s1_count0", count, 0);
      applyStimulus(19);
      checkOutput("s1_count19", count, 19);
      checkOutput("s1_running19", running, 1);
      applyStimulus(1);
      checkOutput("s1_exp_running", running, 0);
      checkOutput("s1_exp_irq", irq, 1);
      checkOutput("s1_exp_count", count, 19);
      checkOutput("s1_exp_next_pid", next_pid, 2);

      // Acknowledge: slot 2 runs, quantum write of 3 must not shorten it
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("s2_cur_pid", cur_pid, 2);
      checkOutput("s2_running", running, 1);
      checkOutput("s2_count0", count, 0);
      checkOutput("s2_next_pid", next_pid, 0);
      quantum_we = 1'b1;
      quantum_in = 16'd3;
      applyStimulus(1);
      quantum_we = 1'b0;
      applyStimulus(18);
      checkOutput("s2_count19", count, 19);
      checkOutput("s2_running19", running, 1);
      applyStimulus(1);
      checkOutput("s2_exp_irq", irq, 1);

      // Next slice uses quantum 3
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("s3_cur_pid", cur_pid, 0);
      checkOutput("s3_running", running, 1);
      applyStimulus(2);
      checkOutput("s3_count2", count, 2);
      checkOutput("s3_running2", running, 1);
      applyStimulus(1);
      checkOutput("s3_exp_irq", irq, 1);
      checkOutput("s3_exp_count", count, 2);

      // Quantum 0 is stored as 1: one-cycle slice
      quantum_we = 1'b1;
      quantum_in = 16'd0;
      applyStimulus(1);
      quantum_we = 1'b0;
      checkOutput("q0_hold_irq", irq, 1);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("q0_running", running, 1);
      checkOutput("q0_cur_pid", cur_pid, 2);
      applyStimulus(1);
      checkOutput("q0_exp_irq", irq, 1);
      checkOutput("q0_exp_count", count, 0);

      // Move to slot 7 and restore a 20-cycle quantum
      proc_en    = 8'h80;
      quantum_we = 1'b1;
      quantum_in = 16'd20;
      applyStimulus(1);
      quantum_we = 1'b0;
      checkOutput("w_next_pid7", next_pid, 7);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("w_cur_pid7", cur_pid, 7);
      checkOutput("w_running", running, 1);

      // Wrap-around search from slot 7
      proc_en = 8'b1000_0010;
      #1;
      checkOutput("w_wrap_next_pid", next_pid, 1);
      applyStimulus(19);
      checkOutput("w_count19", count, 19);
      checkOutput("w_running19", running, 1);
      applyStimulus(1);
      checkOutput("w_exp_irq", irq, 1);
      checkOutput("w_exp_next_pid", next_pid, 1);
      proc_en = 8'h80;
      #1;
      checkOutput("w_self_next_pid", next_pid, 7);
      checkOutput("w_self_next_valid", next_valid, 1);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("w_repeat_cur_pid", cur_pid, 7);
      checkOutput("w_repeat_running", running, 1);
      checkOutput("w_repeat_count", count, 0);

      // Stop on the last cycle of the slice wins over expiry
      applyStimulus(19);
      checkOutput("stop_count19", count, 19);
      stop = 1'b1;
      applyStimulus(1);
      stop = 1'b0;
      checkOutput("stop_running", running, 0);
      checkOutput("stop_irq", irq, 0);
      checkOutput("stop_count", count, 0);
      checkOutput("stop_cur_pid", cur_pid, 7);
      applyStimulus(2);
      checkOutput("stop_irq_later", irq, 0);

      // Stop together with irq_ack in EXPIRED returns to IDLE
      quantum_we = 1'b1;
      quantum_in = 16'd2;
      applyStimulus(1);
      quantum_we = 1'b0;
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("sa_running", running, 1);
      checkOutput("sa_cur_pid", cur_pid, 7);
      applyStimulus(2);
      checkOutput("sa_exp_irq", irq, 1);
      stop    = 1'b1;
      irq_ack = 1'b1;
      applyStimulus(1);
      stop    = 1'b0;
      irq_ack = 1'b0;
      checkOutput("sa_irq", irq, 0);
      checkOutput("sa_running_after", running, 0);

      // Empty ready mask on acknowledge, then start with nothing ready
      proc_en = 8'h04;
      #1;
      checkOutput("em_next_pid", next_pid, 2);
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("em_cur_pid", cur_pid, 2);
      checkOutput("em_running", running, 1);
      applyStimulus(2);
      checkOutput("em_exp_irq", irq, 1);
      proc_en = 8'h00;
      #1;
      checkOutput("em_next_valid", next_valid, 0);
      checkOutput("em_next_pid_held", next_pid, 2);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkOutput("em_ack_running", running, 0);
      checkOutput("em_ack_irq", irq, 0);
      checkOutput("em_ack_cur_pid", cur_pid, 2);
      start = 1'b1;
      applyStimulus(2);
      start = 1'b0;
      checkOutput("em_start_running", running, 0);
      checkOutput("em_start_cur_pid", cur_pid, 2);

      // Asynchronous reset while the interrupt is pending
      proc_en = 8'h04;
      start   = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(2);
      checkOutput("ar_pre_irq", irq, 1);
      checkOutput("ar_pre_count", count, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_irq", irq, 0);
      checkOutput("ar_running", running, 0);
      checkOutput("ar_cur_pid", cur_pid, 0);
      checkOutput("ar_count", count, 0);
      #3;
      reset = 1'b0;

      // Reset restores the 20-cycle default quantum
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("pr_cur_pid", cur_pid, 2);
      checkOutput("pr_running", running, 1);
      applyStimulus(19);
      checkOutput("pr_count19", count, 19);
      checkOutput("pr_running19", running, 1);
      applyStimulus(1);
      checkOutput("pr_exp_irq", irq, 1);
      checkOutput("pr_exp_count", count, 19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_quantum_scheduler.md
Name: rr_quantum_scheduler

Overview:
Parametrised round-robin preemption timer for the kernel. It generalises the fixed-quantum timer in three ways: the time slice is programmable, the block tracks which of NPROC process slots is running, and it selects the next slot round-robin from a ready mask. When a slice expires it raises a kernel interrupt and holds it until the kernel acknowledges. The block sits between the CPU control unit (start/stop/ack/quantum writes) and the OS kernel entry logic.

Parameters:
CNT_W, 16, width of the slice counter and the quantum register
NPROC, 8, number of process slots (2..256)
PID_W, 3, width of the process ID; must satisfy 2**PID_W >= NPROC
DEFAULT_QUANTUM, 20, quantum value loaded at reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin scheduling (timer activate)
stop  input  1  abort scheduling and return to IDLE
quantum_we  input  1  write strobe for quantum_in
quantum_in  input  CNT_W  new quantum, in cycles
proc_en  input  NPROC  ready mask; bit i set means slot i is runnable
irq_ack  input  1  kernel acknowledges the expiry interrupt
running  output  1  a slice is in progress
irq  output  1  slice-expired interrupt to the kernel (level)
cur_pid  output  PID_W  slot owning the current or last slice
next_pid  output  PID_W  next round-robin candidate
next_valid  output  1  at least one slot is ready (|proc_en)
count  output  CNT_W  cycles elapsed in the current slice

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, count=0, cur_pid=0, quantum_reg=DEFAULT_QUANTUM, active_q=DEFAULT_QUANTUM, running=0, irq=0.
- Quantum register:
  - quantum_we latches quantum_in on the clock edge, in any state.
  - A written value of 0 is stored as 1.
  - active_q is copied from quantum_reg only when a slice starts. A write during RUN does not change the slice in progress.
- next_pid (combinational): the first set bit of proc_en searched cyclically from cur_pid+1, wrapping from NPROC-1 to 0, and ending with cur_pid itself.
  - If only cur_pid is ready, next_pid=cur_pid.
  - If proc_en==0, next_pid=cur_pid and next_valid=0.
- States (Moore outputs: running=(state==RUN), irq=(state==EXPIRED)):
  - IDLE:
    - If start=1 and next_valid=1: go to RUN, set count=0, set active_q=quantum_reg.
    - cur_pid takes the first ready slot searched from cur_pid itself, not from cur_pid+1.
    - If start=1 and proc_en==0: stay in IDLE.
    - stop has no effect.
  - RUN:
    - count increments by 1 each cycle.
    - When count==active_q-1, go to EXPIRED on the next edge and hold count at active_q-1.
    - running is high for exactly active_q cycles.
    - stop=1 goes to IDLE with count=0. stop takes priority over expiry on the same cycle.
    - start is ignored.
    - proc_en changes do not end the slice.
  - EXPIRED:
    - irq=1 until acknowledged. count holds its value.
    - irq_ack=1 with next_valid=1: cur_pid<=next_pid, count<=0, active_q<=quantum_reg, go to RUN (back-to-back slice, one-cycle gap).
    - irq_ack=1 with next_valid=0: go to IDLE with cur_pid unchanged.
    - stop=1 goes to IDLE with irq cleared, and takes priority over irq_ack.
- The counter never wraps: the maximum slice is 2**CNT_W-1 cycles.
- Reset asserted mid-slice forces IDLE immediately and deasserts irq and running without waiting for a clock edge.
- Unused encodings (NPROC < 2**PID_W): those slots are never selected.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle -> running=0, irq=0, cur_pid=0, count=0 immediately; after release, quantum is still 20.
- Default slice: proc_en=8'b00000101, pulse start from IDLE -> cur_pid=0, running high for exactly 20 cycles, then irq=1 with next_pid=2. Pulse irq_ack -> cur_pid=2, a new 20-cycle slice runs, next_pid=0.
- Wrap-around: cur_pid=7, proc_en=8'b10000010, expiry -> next_pid=1. With proc_en=8'b10000000 -> next_pid=7, and the slice repeats for slot 7.
- Quantum programming: write 3 during RUN -> the current slice stays 20 cycles, the next slice is 3 cycles. Write 0 -> slices are 1 cycle.
- Stop priority: stop asserted on the same cycle count reaches 19 -> IDLE, irq never asserts. Stop and irq_ack together in EXPIRED -> IDLE, irq=0.
- Empty ready mask: in EXPIRED set proc_en=0 and ack -> IDLE, cur_pid held, next_valid=0. Start with proc_en=0 -> stays IDLE.
